// File: rtl/crypto_keyslot_wrapper.sv
// Register-mapped front end for a block-cipher core with N_KEYS selectable key slots.
// Define KEYSLOT_ZEROIZE_EN to enable CTRL zeroize and the key wipe on timeout.
module crypto_keyslot_wrapper #(
   parameter int unsigned N_KEYS    = 3,
   parameter int unsigned KEY_WORDS = 6,
   parameter int unsigned BLK_WORDS = 4,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              reglk_ctrl_i,
   input  logic                    reg_valid_i,
   input  logic                    reg_write_i,
   input  logic [31:0]             reg_addr_i,
   input  logic [31:0]             reg_wdata_i,
   output logic                    reg_ready_o,
   output logic [31:0]             reg_rdata_o,
   output logic                    reg_error_o,
   output logic                    core_start_o,
   output logic [32*BLK_WORDS-1:0] core_pt_o,
   output logic [32*KEY_WORDS-1:0] core_key_o,
   input  logic [32*BLK_WORDS-1:0] core_ct_i,
   input  logic                    core_ct_valid_i,
   output logic                    busy_o,
   output logic                    irq_o
);
   localparam int unsigned KS_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
   localparam int unsigned KW_W  = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int unsigned BW_W  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   localparam int unsigned IDX_W = 7;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

   state_t           state;
   logic [31:0]      key_q [N_KEYS][KEY_WORDS];
   logic [31:0]      pt_q  [BLK_WORDS];
   logic [31:0]      ct_q  [BLK_WORDS];
   logic [KS_W-1:0]  key_sel_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] cnt_q;

   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] kofs;
   logic [3:0]       dec_k;
   logic [2:0]       dec_w;
   logic [BW_W-1:0]  blk_idx;
   logic             is_ctrl, is_stat, is_ksel, is_pt, is_ct, is_key;
   logic             illegal, rd_lock, wr_lock;
   logic             accept, wr_en, resp_err, zero_req, start_c;
   logic [31:0]      rdata_c;
   logic             unused_bits;

   assign unused_bits = ^{reg_addr_i[31:9], reg_addr_i[1:0], reglk_ctrl_i[7], reglk_ctrl_i[0]};

   // Address decode, lock/busy qualification and read mux for the request on the bus
   always_comb begin
      idx      = reg_addr_i[8:2];
      kofs     = idx - 7'd16;
      dec_k    = kofs[6:3];
      dec_w    = kofs[2:0];
      blk_idx  = BW_W'(idx[1:0]);
      is_ctrl  = (idx == 7'd0);
      is_stat  = (idx == 7'd1);
      is_ksel  = (idx == 7'd2);
      is_pt    = (idx[6:2] == 5'd1) && (32'(idx[1:0]) < BLK_WORDS);
      is_ct    = (idx[6:2] == 5'd2) && (32'(idx[1:0]) < BLK_WORDS);
      is_key   = (idx >= 7'd16) && (32'(dec_k) < N_KEYS) && (32'(dec_w) < KEY_WORDS);
      illegal  = !(is_ctrl || is_stat || is_ksel || is_pt || is_ct || is_key) ||
                 (!reg_write_i && is_key) || (reg_write_i && is_ct);
      rd_lock  = (is_pt && reglk_ctrl_i[2]) || (is_ct && reglk_ctrl_i[4]) ||
                 (is_stat && reglk_ctrl_i[6]);
      wr_lock  = (is_ctrl && reglk_ctrl_i[1]) || (is_pt && reglk_ctrl_i[3]) ||
                 ((is_key || is_ksel) && reglk_ctrl_i[5]);
      accept   = reg_valid_i && !reg_ready_o;
      resp_err = 1'b0;
      wr_en    = 1'b0;
      rdata_c  = '0;
      zero_req = 1'b0;
`ifdef KEYSLOT_ZEROIZE_EN
      zero_req = reg_wdata_i[1] && !reglk_ctrl_i[5];
`endif
      if (illegal) begin
         resp_err = 1'b1;
      end else if (reg_write_i) begin
         if (!wr_lock) begin
            if (busy_o && (is_pt || is_key || is_ksel))
               resp_err = 1'b1;
            else if (busy_o && is_ctrl && (reg_wdata_i[0] || zero_req))
               resp_err = 1'b1;
            else if (is_ksel && (reg_wdata_i >= N_KEYS))
               resp_err = 1'b1;
            else
               wr_en = 1'b1;
         end
      end else if (!rd_lock) begin
         if (is_stat)      rdata_c = {29'b0, timeout_q, done_q, busy_o};
         else if (is_ksel) rdata_c = 32'(key_sel_q);
         else if (is_pt)   rdata_c = pt_q[blk_idx];
         else if (is_ct)   rdata_c = ct_q[blk_idx];
      end
      start_c = accept && wr_en && is_ctrl && reg_wdata_i[0];
   end

   always_comb begin
      core_pt_o = '0;
      for (int unsigned b = 0; b < BLK_WORDS; b++)
         core_pt_o[32*b +: 32] = pt_q[BW_W'(b)];
   end

   // Bus response, register file and launch/wait/timeout sequencer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         key_q        <= '{default: '0};
         pt_q         <= '{default: '0};
         ct_q         <= '{default: '0};
         key_sel_q    <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
         reg_ready_o  <= 1'b0;
         reg_rdata_o  <= '0;
         reg_error_o  <= 1'b0;
         core_start_o <= 1'b0;
         core_key_o   <= '0;
         busy_o       <= 1'b0;
         irq_o        <= 1'b0;
      end else begin
         reg_ready_o  <= accept;
         reg_rdata_o  <= accept ? rdata_c : '0;
         reg_error_o  <= accept && resp_err;
         core_start_o <= 1'b0;
         irq_o        <= 1'b0;

         if (accept && wr_en) begin
            if (is_pt)   pt_q[blk_idx] <= reg_wdata_i;
            if (is_key)  key_q[KS_W'(dec_k)][KW_W'(dec_w)] <= reg_wdata_i;
            if (is_ksel) key_sel_q <= KS_W'(reg_wdata_i);
            if (is_stat && reg_wdata_i[1]) done_q    <= 1'b0;
            if (is_stat && reg_wdata_i[2]) timeout_q <= 1'b0;
`ifdef KEYSLOT_ZEROIZE_EN
            if (is_ctrl && zero_req) key_q[key_sel_q] <= '{default: '0};
`endif
         end

         // Status sets come after the W1C above so a same-cycle completion wins
         case (state)
            S_IDLE: begin
               if (start_c) begin
                  state        <= S_LAUNCH;
                  core_start_o <= 1'b1;
                  busy_o       <= 1'b1;
               end
            end
            S_LAUNCH: begin
               done_q    <= 1'b0;
               timeout_q <= 1'b0;
               cnt_q     <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (core_ct_valid_i) begin
                  for (int unsigned b = 0; b < BLK_WORDS; b++)
                     ct_q[BW_W'(b)] <= core_ct_i[32*b +: 32];
                  done_q <= 1'b1;
                  irq_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  irq_o     <= 1'b1;
                  busy_o    <= 1'b0;
                  state     <= S_IDLE;
`ifdef KEYSLOT_ZEROIZE_EN
                  key_q     <= '{default: '0};
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase

         for (int unsigned w = 0; w < KEY_WORDS; w++)
            core_key_o[32*w +: 32] <= key_q[key_sel_q][KW_W'(w)];
      end
   end

endmodule

// File: doc/crypto_keyslot_wrapper.md
# crypto_keyslot_wrapper

Register-mapped front end for a block-cipher core with N selectable key slots. It is the parametrised successor to the single-AES-192 wrapper. Software loads plaintext and keys over a 32-bit register bus, selects a slot, and starts an operation. A launch/wait/timeout state machine sequences the core, and the block exposes busy, done and timeout status. Per-field register locks are driven by `reglk_ctrl_i`.

## Interface
- `N_KEYS`, 3: key slots, 1..14.
- `KEY_WORDS`, 6: 32-bit words per key, 1..8.
- `BLK_WORDS`, 4: 32-bit words per data block, 1..4.
- `TIMEOUT`, 64: maximum cycles in WAIT before abort, ≥2.
- `clk_i` in 1: single clock; all logic posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `reglk_ctrl_i` in 8: lock bits.
  - [1] CTRL write lock; [2] PT read lock; [3] PT write lock; [4] CT read lock.
  - [5] KEY/KEY_SEL write lock; [6] STATUS read lock.
- `reg_valid_i` in 1, `reg_write_i` in 1, `reg_addr_i` in 32, `reg_wdata_i` in 32: bus request.
- `reg_ready_o` out 1, `reg_rdata_o` out 32, `reg_error_o` out 1: bus response.
- `core_start_o` out 1: one-cycle launch pulse to the core.
- `core_pt_o` out 32·BLK_WORDS: word 0 in the LSBs.
- `core_key_o` out 32·KEY_WORDS: the selected slot.
- `core_ct_i` in 32·BLK_WORDS, `core_ct_valid_i` in 1: core result.
- `busy_o` out 1, `irq_o` out 1: irq is a one-cycle pulse when done or timeout is set.

## Operation
- Word index is `reg_addr_i[8:2]`.
  - 0 CTRL (W): bit0 start; bit1 zeroize.
  - 1 STATUS (R): {29'b0, timeout, done, busy}. Writes are W1C on bits 2:1.
  - 2 KEY_SEL (R/W): $clog2(N_KEYS) bits.
  - 4+i PT word i (R/W).
  - 8+i CT word i (R only).
  - 16+8k+w key k word w (W only).
- Unmapped index, key read, CT write, KEY_SEL ≥ N_KEYS, or bit beyond width → `reg_error_o`=1, no state change.
- Locked read returns 0 with error=0. Locked write is ignored with error=0.
- Writes to PT, KEY or KEY_SEL while busy are ignored with error=1.
- Start written while busy or while locked is ignored. A busy start also returns error=1.
- FSM: IDLE → LAUNCH on start=1.
  - LAUNCH: `core_start_o`=1 for one cycle, clear done and timeout, → WAIT.
  - WAIT: counter increments each cycle.
  - WAIT on `core_ct_valid_i`: capture CT, set done, pulse irq, → IDLE.
  - WAIT when counter reaches TIMEOUT−1 without valid: set timeout, keep CT, pulse irq, → IDLE.
  - busy_o=1 in LAUNCH and WAIT.
- `core_ct_valid_i` outside WAIT is ignored.
- PT, key and KEY_SEL are frozen while busy, so core inputs are stable through the operation.

## Timing
- Bus: a request is accepted when `reg_valid_i`=1 and no response is pending.
  - `reg_ready_o` pulses high one cycle later, with registered `reg_rdata_o` and `reg_error_o`.
  - The master holds the request until ready. Back-to-back requests give one response every 2 cycles.
- Start write in cycle t:
  - LAUNCH in t+1, with `core_start_o`=1.
  - WAIT from t+2.
  - Valid seen in cycle v: done=1, CT updated and irq pulse in v+1; busy_o=0 in v+1.
- Timeout: irq and timeout=1 exactly TIMEOUT cycles after WAIT entry.
- Valid and W1C of done in the same cycle: the set wins.
- Reset values: all outputs 0; FSM IDLE; PT, CT, keys, KEY_SEL, status and counter 0.
  - Reset mid-operation aborts immediately. No irq is issued. Late core valid is ignored.

## Configuration
- `KEYSLOT_ZEROIZE_EN` defined:
  - CTRL bit1 clears all KEY_WORDS words of the selected slot in one cycle. This is subject to lock bit [5] and to not busy; a busy zeroize returns error=1.
  - A timeout also zeroizes every slot.
- Undefined: CTRL bit1 is ignored; keys persist across timeouts; no zeroize logic is synthesised.

## Test plan
- Load slot 2, KEY_SEL=2, PT=0x00112233_44556677_8899aabb_ccddeeff, start. The core model returns valid 12 cycles after start. Expected: `core_key_o`=slot 2, one `core_start_o` pulse, CT readable at 8..11, STATUS=0x2, one irq.
- Same flow with the core never asserting valid, TIMEOUT=64. Expected: timeout bit set 64 cycles after WAIT entry, CT unchanged at 0, busy_o=0. With `KEYSLOT_ZEROIZE_EN`, all key slots also read back as zero via `core_key_o`.
- `reglk_ctrl_i`=0x3C: PT write and key write are ignored, PT read returns 0, CT read returns 0, all with error=0. A start write still launches because bit1=0.
- While busy, write PT word 0 and start. Expected: both error=1, PT unchanged, a single operation completes.
- Read index 16, read index 3, write KEY_SEL=N_KEYS. Expected: error=1 for each, no state change.
- Assert `rst_i` during WAIT, then assert core valid. Expected: all outputs 0, no irq, STATUS=0.
